// File: rtl/rl_ram_pkg.sv
// rl_ram_pkg: shared types and constants for the 1R1W RAM stream reader
package rl_ram_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/rl_ram_1r1w_stream_reader_skid.sv
// rl_skid_fifo2: 2-entry register FIFO with registered head output and no fall-through
module rl_skid_fifo2
    import rl_ram_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   cnt_o
);
    logic [W-1:0] r_head, r_tail;
    logic [1:0]   r_cnt;
    logic         w_pop;
    assign w_pop  = pop_i && (r_cnt != 2'd0);
    assign dout_o = r_head;
    assign cnt_o  = r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop && r_cnt == 2'd2)
                r_head <= r_tail;
            else if (push_i && (r_cnt == 2'd0 || w_pop))
                r_head <= din_i;
            if (push_i && r_cnt != 2'd0 && !(w_pop && r_cnt == 2'd1))
                r_tail <= din_i;
            r_cnt <= r_cnt + {1'b0, push_i} - {1'b0, w_pop};
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (!(push_i && !w_pop && r_cnt == 2'(SKID_DEPTH)));
    end
endmodule

// File: rtl/rl_ram_1r1w_stream_reader.sv
// rl_ram_1r1w_stream_reader: burst reader for a 1-cycle-latency 1R1W RAM with credit-limited skid output
module rl_ram_1r1w_stream_reader
    import rl_ram_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [ABITS-1:0] cmd_addr_i,
    input  logic [ABITS-1:0] cmd_len_i,
    output logic [ABITS-1:0] ram_raddr_o,
    input  logic [DBITS-1:0] ram_rdata_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [DBITS-1:0] m_data_o,
    output logic             m_last_o,
    output logic             busy_o
);
    rd_state_t        r_state;
    logic [ABITS-1:0] r_addr, r_rem;
    logic             r_inflight, r_last_inflight, r_cmd_ready, r_busy;
    logic [1:0]       w_cnt;
    logic [2:0]       w_credit;
    logic [DBITS:0]   w_head;
    logic             w_pop, w_issue;
    assign w_pop       = m_valid_o && m_ready_i;
    assign w_credit    = {1'b0, w_cnt} + {2'b0, r_inflight};
    // a pop this cycle frees a slot, so it counts as credit for the next issue
    assign w_issue     = (r_state == RUN) && (w_credit < 3'(SKID_DEPTH) + {2'b0, w_pop});
    assign ram_raddr_o = r_addr;
    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = r_busy;
    assign m_valid_o   = (w_cnt != 2'd0);
    assign m_data_o    = w_head[DBITS:1];
    assign m_last_o    = w_head[0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_last_inflight <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_last_inflight <= w_issue && (r_rem == '0);
            case (r_state)
                IDLE: if (cmd_valid_i) begin
                    r_addr      <= cmd_addr_i;
                    r_rem       <= cmd_len_i;
                    r_state     <= RUN;
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b1;
                end
                RUN: if (w_issue) begin
                    if (r_rem == '0)
                        r_state <= DRAIN;
                    else begin
                        r_addr <= r_addr + ABITS'(1);
                        r_rem  <= r_rem - ABITS'(1);
                    end
                end
                DRAIN: if (w_cnt == 2'd0 && !r_inflight) begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    rl_skid_fifo2 #(.W(DBITS + 1)) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (r_inflight),
        .din_i  ({ram_rdata_i, r_last_inflight}),
        .pop_i  (w_pop),
        .dout_o (w_head),
        .cnt_o  (w_cnt)
    );
endmodule

// File: tb/tb_rl_ram_1r1w_stream_reader.sv
// tb_rl_ram_1r1w_stream_reader: directed bursts on ABITS=10 and ABITS=4 instances fed by RAM models
module tb_rl_ram_1r1w_stream_reader;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        cmd_valid = 1'b0, m_ready = 1'b1;
    logic [9:0]  cmd_addr = '0, cmd_len = '0;
    logic        a_cmd_ready, a_valid, a_last, a_busy;
    logic [9:0]  a_raddr;
    logic [31:0] a_rdata, a_data;
    logic        b_cmd_ready, b_valid, b_last, b_busy;
    logic [3:0]  b_raddr;
    logic [31:0] b_rdata, b_data;
    logic        cmd_ready, m_valid, m_last, busy;
    logic [31:0] m_data;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [16];
    int          total = 0, bad = 0;

    assign cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
    assign m_valid   = sel ? b_valid : a_valid;
    assign m_last    = sel ? b_last : a_last;
    assign m_data    = sel ? b_data : a_data;
    assign busy      = sel ? b_busy : a_busy;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        a_rdata <= mem_a[a_raddr];
        b_rdata <= mem_b[b_raddr];
    end

    rl_ram_1r1w_stream_reader #(.ABITS(10), .DBITS(32)) u_a (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid && !sel), .cmd_ready_o(a_cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .ram_raddr_o(a_raddr), .ram_rdata_i(a_rdata),
        .m_valid_o(a_valid), .m_ready_i(m_ready), .m_data_o(a_data), .m_last_o(a_last), .busy_o(a_busy)
    );
    rl_ram_1r1w_stream_reader #(.ABITS(4), .DBITS(32)) u_b (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid && sel), .cmd_ready_o(b_cmd_ready),
        .cmd_addr_i(cmd_addr[3:0]), .cmd_len_i(cmd_len[3:0]), .ram_raddr_o(b_raddr), .ram_rdata_i(b_rdata),
        .m_valid_o(b_valid), .m_ready_i(m_ready), .m_data_o(b_data), .m_last_o(b_last), .busy_o(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic burst(input bit s, input int addr, input int len, input int mode, input int rst_after);
        int          got = 0, cyc = 0, first = -1, n = 0;
        logic        r, pstall = 1'b0, plast = 1'b0;
        logic [31:0] pdata = '0, exp;
        sel = s;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 10'(addr);
        cmd_len   = 10'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (got <= len && cyc < 300) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            check("cmd_ready_busy", cmd_ready, 0);
            if (pstall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, pdata);
                check("stall_last", m_last, plast);
            end
            if (m_valid && first < 0) first = cyc;
            m_ready = r;
            if (m_valid && r) begin
                exp = s ? mem_b[(addr + got) % 16] : mem_a[(addr + got) % 1024];
                check("data", m_data, exp);
                check("last", m_last, got == len);
                got++;
                if (rst_after != 0 && got == rst_after) begin
                    @(negedge clk);
                    m_ready = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    m_ready = 1'b1;
                    check("rst_valid", m_valid, 0);
                    check("rst_cmd_ready", cmd_ready, 1);
                    check("rst_busy", busy, 0);
                    return;
                end
            end
            pstall = m_valid && !r;
            pdata  = m_data;
            plast  = m_last;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b1;
        check("word_count", got, len + 1);
        if (mode == 0) begin
            check("first_latency", first, 2);
            check("no_bubbles", cyc, len + 3);
        end
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall", busy, 0);
        check("cmd_ready_end", cmd_ready, 1);
        check("valid_end", m_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'(i);
        mem_a[5] = 32'hA5A5_0001;
        for (int i = 0; i < 16; i++) mem_b[i] = 32'hB000_0000 + 32'(i);
        repeat (3) @(negedge clk);
        check("rst_a_cmd_ready", a_cmd_ready, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_last", a_last, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_raddr", a_raddr, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_cmd_ready", b_cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        burst(0, 5, 0, 0, 0);
        burst(0, 16, 7, 0, 0);
        burst(0, 16, 7, 1, 0);
        burst(0, 16, 7, 2, 0);
        burst(1, 14, 3, 0, 0);
        burst(1, 3, 15, 0, 0);
        burst(1, 3, 15, 1, 0);
        burst(0, 100, 31, 0, 5);
        burst(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
